// File: rtl/sr_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_ctrl_pkg
// Brief    : Shared types and constants for the SR flop bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sr_ctrl_pkg;

  // Command life cycle: wait for a command, pulse the bank, read it back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Requester op encoding.
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Default geometry.
  localparam int DEF_NREQ = 4;
  localparam int DEF_NFF  = 8;
  localparam int DEF_IDXW = 3;

  // Width of a requester id; never below one bit so a single requester still works.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_arbiter_if
// Brief    : Requester, bank and completion signals of the SR bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_bank_arbiter_if
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NFF  = DEF_NFF,
  parameter int IDXW = DEF_IDXW
);
  localparam int IDW = id_width(NREQ);

  // Requester side
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic                 clr_all;
  logic                 clr_ready;

  // Bank side
  logic [NFF-1:0]       s_out;
  logic [NFF-1:0]       r_out;
  logic [NFF-1:0]       q_in;

  // Status / completion
  logic                 busy;
  logic                 done_valid;
  logic [IDW-1:0]       done_id;
  logic                 done_all;
  logic                 done_ok;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_op, req_idx, clr_all, q_in,
    output req_ready, clr_ready, s_out, r_out, busy,
           done_valid, done_id, done_all, done_ok
  );

  // Requesters plus the flop bank.
  modport master (
    output req_valid, req_op, req_idx, clr_all, q_in,
    input  req_ready, clr_ready, s_out, r_out, busy,
           done_valid, done_id, done_all, done_ok
  );

endinterface
`default_nettype wire

// File: rtl/sr_bank_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Search starts just after the
//            last winner (ptr_i) and wraps; the pointer is held by the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_req_o
);

  logic w_found;
  int   w_cand;

  // Walk the requesters in priority order ptr+1, ptr+2, ... and take the first.
  always_comb begin
    grant_o   = '0;
    id_o      = '0;
    w_found   = 1'b0;
    w_cand    = 0;
    any_req_o = |req_i;
    for (int off = 1; off <= NREQ; off++) begin
      w_cand = (int'(ptr_i) + off) % NREQ;
      if (!w_found && req_i[w_cand]) begin
        w_found         = 1'b1;
        grant_o[w_cand] = 1'b1;
        id_o            = IDW'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_arbiter
// Brief    : Shares one bank of SR flops between several requesters. One
//            command at a time is pulsed into the bank, read back, and
//            reported with a pass/fail flag. s and r are never both driven.
// Revision : 1.0 - initial release
// ============================================================================
module sr_bank_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NFF  = DEF_NFF,
  parameter int IDXW = DEF_IDXW
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_arbiter_if.slave bus
);

  localparam int IDW = id_width(NREQ);

  // Control state
  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  // Latched command
  logic            op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            all_q, all_d;

  // Registered bank drive and completion report
  logic [NFF-1:0]  s_q, s_d;
  logic [NFF-1:0]  r_q, r_d;
  logic            done_valid_q, done_valid_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic            done_all_q, done_all_d;
  logic            done_ok_q, done_ok_d;

  // Arbitration and decode helpers
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_win_id;
  logic            w_any_req;
  logic            w_sel_op;
  logic [IDXW-1:0] w_sel_idx;
  logic [NFF-1:0]  w_sel_onehot;
  logic            w_q_bit;
  logic            w_idx_ok;
  logic [NREQ-1:0] w_req_ready;
  logic            w_clr_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (w_grant),
    .id_o      (w_win_id),
    .any_req_o (w_any_req)
  );

  // Select the op and index of the requester the arbiter picked.
  always_comb begin
    w_sel_op  = OP_CLR;
    w_sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_op  = bus.req_op[k];
        w_sel_idx = bus.req_idx[k*IDXW +: IDXW];
      end
    end
  end

  // One-hot decode of the selected index; indices past the bank decode to zero.
  always_comb begin
    w_sel_onehot = '0;
    for (int i = 0; i < NFF; i++) begin
      if (w_sel_idx == IDXW'(i)) begin
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  // Readback of the latched flop; w_idx_ok stays low for an out-of-range index.
  always_comb begin
    w_q_bit  = 1'b0;
    w_idx_ok = 1'b0;
    for (int i = 0; i < NFF; i++) begin
      if (idx_q == IDXW'(i)) begin
        w_q_bit  = bus.q_in[i];
        w_idx_ok = 1'b1;
      end
    end
  end

  // Next-state, grant and registered-output decisions.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    idx_d        = idx_q;
    id_d         = id_q;
    all_d        = all_q;
    s_d          = '0;
    r_d          = '0;
    done_valid_d = 1'b0;
    done_id_d    = '0;
    done_all_d   = 1'b0;
    done_ok_d    = 1'b0;
    w_req_ready  = '0;
    w_clr_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so nothing appears accepted.
        if (!rst) begin
          if (bus.clr_all) begin
            // Clear-all beats every requester and leaves the pointer alone.
            w_clr_ready = 1'b1;
            op_d        = OP_CLR;
            idx_d       = '0;
            id_d        = '0;
            all_d       = 1'b1;
            r_d         = '1;
            state_d     = DRIVE;
          end else if (w_any_req) begin
            w_req_ready = w_grant;
            op_d        = w_sel_op;
            idx_d       = w_sel_idx;
            id_d        = w_win_id;
            all_d       = 1'b0;
            ptr_d       = w_win_id;
            if (w_sel_op == OP_SET) begin
              s_d = w_sel_onehot;
            end else begin
              r_d = w_sel_onehot;
            end
            state_d     = DRIVE;
          end
        end
      end
      DRIVE: begin
        // The pulse was launched on the accept edge; let it drop now.
        state_d = CHECK;
      end
      CHECK: begin
        state_d      = IDLE;
        done_valid_d = 1'b1;
        done_id_d    = id_q;
        done_all_d   = all_q;
        done_ok_d    = all_q ? (bus.q_in == '0) : (w_idx_ok && (w_q_bit == op_q));
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      op_q         <= OP_CLR;
      idx_q        <= '0;
      id_q         <= '0;
      all_q        <= 1'b0;
      s_q          <= '0;
      r_q          <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_all_q   <= 1'b0;
      done_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      all_q        <= all_d;
      s_q          <= s_d;
      r_q          <= r_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_all_q   <= done_all_d;
      done_ok_q    <= done_ok_d;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.clr_ready  = w_clr_ready;
  assign bus.s_out      = s_q;
  assign bus.r_out      = r_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_all   = done_all_q;
  assign bus.done_ok    = done_ok_q;

endmodule
`default_nettype wire
